registro_pipeline: RTL

Parametrised register pipeline with valid/ready handshake, per-stage enable derived from back-pressure, bubble collapsing and synchronous flush. It generalises the single enable-gated D register to a configurable width and depth. It sits between any producer/consumer pair in the datapath that needs fixed-latency retiming with flow control.

---
 rtl/registro_pipeline_pkg.sv | 31 +++
 rtl/registro_pipeline_etapa.sv | 40 ++++
 rtl/registro_pipeline.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/registro_pipeline_pkg.sv
// registro_pipeline_pkg
// Shared constants and helpers for the registro_pipeline slice.
//   DEFAULT_WIDTH / DEFAULT_DEPTH : default beat width and stage count
//   clog2_f                       : ceiling log2, minimum result 1
// Optional feature macro: REGISTRO_PIPELINE_BYPASS_EN (same-cycle din->dout
// path when the pipeline is empty). The guard itself lives in the top level
// so that the default build contains no combinational din->dout path.
package registro_pipeline_pkg;

  localparam int DEFAULT_WIDTH = 32'sd12;
  localparam int DEFAULT_DEPTH = 32'sd3;

  // Ceiling log2, clamped to 1 so that a counter is never zero bits wide.
  function automatic int clog2_f(input int n);
    int r;
    int v;
    r = 32'sd0;
    v = n - 32'sd1;
    while (v > 32'sd0) begin
      r = r + 32'sd1;
      v = v >>> 1;
    end
    if (r < 32'sd1) begin
      r = 32'sd1;
    end else begin
      r = r;
    end
    return r;
  endfunction

endpackage

// File: rtl/registro_pipeline_etapa.sv
// etapa_pipeline
// One register stage of registro_pipeline: a data register and a valid flag.
// The valid flag and the data word have independent load strobes so the data
// register only toggles when a real beat arrives.
// Ports:
//   clk, reset      rising-edge clock, asynchronous active-low reset
//   load_vld, vld_d valid flag load strobe and next value
//   load_data, data_d data load strobe and next value
//   data_q, vld_q   registered stage contents
module etapa_pipeline
  import registro_pipeline_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_vld,
  input  logic             vld_d,
  input  logic             load_data,
  input  logic [WIDTH-1:0] data_d,
  output logic [WIDTH-1:0] data_q,
  output logic             vld_q
);

  // Stage storage: valid flag and data word, each with its own load strobe.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vld_q  <= 1'b0;
      data_q <= {WIDTH{1'b0}};
    end else begin
      if (load_vld) begin
        vld_q <= vld_d;
      end
      if (load_data) begin
        data_q <= data_d;
      end
    end
  end

endmodule

// File: rtl/registro_pipeline.sv
// registro_pipeline
// Fixed-latency register pipeline with valid/ready flow control, bubble
// collapsing and a synchronous flush. DEPTH etapa_pipeline stages are chained;
// stage 0 takes the input beat, stage DEPTH-1 drives the output.
// Ports:
//   clk, reset            rising-edge clock, asynchronous active-low reset
//   clr                   synchronous flush (drops every stored beat)
//   din, valid_in         input beat / offered
//   ready_out             input beat accepted this cycle
//   dout, valid_out       output beat / offered (dout holds when not valid)
//   ready_in              consumer accepts output beat
//   occupancy             number of valid stages (registered)
// Optional feature: define REGISTRO_PIPELINE_BYPASS_EN to let a beat pass
// straight from din to dout in the same cycle when the pipeline is empty and
// the consumer is ready; such a beat is never stored.
// Note: ready_out depends combinationally on ready_in through the advance
// chain, so ready_in must not be derived from ready_out.
module registro_pipeline
  import registro_pipeline_pkg::*;
#(
  parameter  int WIDTH = DEFAULT_WIDTH,
  parameter  int DEPTH = DEFAULT_DEPTH,
  localparam int OCC_W = clog2_f(DEPTH + 32'sd1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic [WIDTH-1:0] din,
  input  logic             valid_in,
  output logic             ready_out,
  output logic [WIDTH-1:0] dout,
  output logic             valid_out,
  input  logic             ready_in,
  output logic [OCC_W-1:0] occupancy
);

  logic [DEPTH:0]   adv_s;
  logic [DEPTH-1:0] vld_s;
  logic [DEPTH-1:0] vld_next_s;
  logic [DEPTH-1:0] load_vld_s;
  logic [DEPTH-1:0] vld_d_s;
  logic [WIDTH-1:0] data_s [DEPTH];
  logic             bypass_s;
  logic [OCC_W-1:0] occ_next_s;
  logic [OCC_W-1:0] occ_r;

  // Advance chain: a stage may load when it is empty or its content moves on.
  // An empty stage therefore always accepts, which is what closes bubbles.
  always_comb begin
    adv_s        = {(DEPTH + 1){1'b0}};
    adv_s[DEPTH] = ready_in;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      adv_s[i] = ~vld_s[i] | adv_s[i + 1];
    end
  end

  assign ready_out = adv_s[0] & ~clr & reset;

`ifdef REGISTRO_PIPELINE_BYPASS_EN
  // Empty pipeline and a ready consumer: the beat goes straight through.
  assign bypass_s = reset & ~clr & valid_in & ready_in & ~(|vld_s);
  assign dout     = bypass_s ? din : data_s[DEPTH-1];
`else
  assign bypass_s = 1'b0;
  assign dout     = data_s[DEPTH-1];
`endif

  assign valid_out = vld_s[DEPTH-1] | bypass_s;

  for (genvar i = 0; i < DEPTH; i++) begin : g_stage
    logic [WIDTH-1:0] src_data_s;
    logic             src_vld_s;
    logic             tail_byp_s;
    logic             load_data_s;
    logic [WIDTH-1:0] data_d_s;

    if (i == 0) begin : g_head
      // A bypassed beat is consumed directly and must not also be stored.
      assign src_data_s = din;
      assign src_vld_s  = valid_in & ~bypass_s;
    end else begin : g_body
      assign src_data_s = data_s[i-1];
      assign src_vld_s  = vld_s[i-1];
    end

    if (i == DEPTH - 1) begin : g_tail
      // The tail data register captures a bypassed beat so dout keeps
      // showing it once valid_out drops.
      assign tail_byp_s = bypass_s;
    end else begin : g_mid
      assign tail_byp_s = 1'b0;
    end

    // Flush forces every valid flag low but leaves the data words alone.
    assign load_vld_s[i] = clr | adv_s[i];
    assign vld_d_s[i]    = ~clr & src_vld_s;
    assign load_data_s   = (~clr & adv_s[i] & src_vld_s) | tail_byp_s;
    assign data_d_s      = tail_byp_s ? din : src_data_s;

    etapa_pipeline #(
      .WIDTH (WIDTH)
    ) u_etapa (
      .clk       (clk),
      .reset     (reset),
      .load_vld  (load_vld_s[i]),
      .vld_d     (vld_d_s[i]),
      .load_data (load_data_s),
      .data_d    (data_d_s),
      .data_q    (data_s[i]),
      .vld_q     (vld_s[i])
    );
  end

  // Next-state valid vector, used only to keep occupancy aligned with vld_q.
  always_comb begin
    vld_next_s = {DEPTH{1'b0}};
    for (int i = 0; i < DEPTH; i++) begin
      if (load_vld_s[i]) begin
        vld_next_s[i] = vld_d_s[i];
      end else begin
        vld_next_s[i] = vld_s[i];
      end
    end
  end

  // Popcount of the next valid vector.
  always_comb begin
    occ_next_s = {OCC_W{1'b0}};
    for (int i = 0; i < DEPTH; i++) begin
      occ_next_s = occ_next_s + OCC_W'(vld_next_s[i]);
    end
  end

  // Occupancy register, updated on the same edge as the stage valid flags.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      occ_r <= {OCC_W{1'b0}};
    end else begin
      occ_r <= occ_next_s;
    end
  end

  assign occupancy = occ_r;

endmodule
